sigverify_sched: RTL

//  Job scheduler in front of one sigverifier core. Queues verification requests (tagged by ID),

---
 rtl/sigverify_sched.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sigverify_sched.sv
// Job scheduler in front of a single sigverifier core: queues tagged requests, launches the core,
// enforces a watchdog, returns pass/fail/timeout per tag. Define SIGSCHED_STATS_EN for result counters.
module sigverify_sched #(
  parameter int ID_W           = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int START_CYCLES   = 10,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [ID_W-1:0] req_id,
  output logic            ver_rst_b,
  output logic            ver_start,
  input  logic            ver_finish,
  input  logic            ver_sigvalid,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [ID_W-1:0] rsp_id,
  output logic            rsp_pass,
  output logic            rsp_timeout,
  output logic            busy
`ifdef SIGSCHED_STATS_EN
  ,
  output logic [15:0]     stat_pass,
  output logic [15:0]     stat_fail,
  output logic [15:0]     stat_timeout
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(START_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, START, WAIT, RECOVER, RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   start_cnt;
  logic [TW-1:0]   to_cnt;
  logic [ID_W-1:0] cur_id;
  logic            rdy_en, finish_q, rec_cnt;
  logic            full, empty, push, pop, finish_edge;

  assign full        = (count == CW'(FIFO_DEPTH));
  assign empty       = (count == '0);
  // rdy_en holds req_ready low during reset and for the release cycle itself.
  assign req_ready   = rdy_en & ~full;
  assign push        = req_valid & req_ready;
  assign pop         = (state == IDLE) & ~empty;
  assign finish_edge = ver_finish & ~finish_q;
  assign busy        = (state != IDLE) | ~empty;
  assign rsp_id      = cur_id;

  // NOTE: queue storage carries no reset; only pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_id;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      start_cnt   <= '0;
      to_cnt      <= '0;
      cur_id      <= '0;
      rdy_en      <= 1'b0;
      finish_q    <= 1'b0;
      rec_cnt     <= 1'b0;
      ver_rst_b   <= 1'b0;
      ver_start   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_pass    <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
      rdy_en    <= 1'b1;
      finish_q  <= ver_finish;
      ver_rst_b <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);

      case (state)
        IDLE: begin
          if (pop) begin
            cur_id    <= mem[rd_ptr];
            start_cnt <= SW'(START_CYCLES - 1);
            ver_start <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (start_cnt == '0) begin
            ver_start <= 1'b0;
            to_cnt    <= '0;
            state     <= WAIT;
          end else begin
            start_cnt <= start_cnt - 1'b1;
          end
        end
        WAIT: begin
          // A finish edge on the watchdog's last cycle still counts as a real verdict.
          if (finish_edge) begin
            rsp_pass    <= ver_sigvalid;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            ver_rst_b <= 1'b0;
            rec_cnt   <= 1'b0;
            state     <= RECOVER;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RECOVER: begin
          if (!rec_cnt) begin
            ver_rst_b <= 1'b0;
            rec_cnt   <= 1'b1;
          end else begin
            rsp_pass    <= 1'b0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SIGSCHED_STATS_EN
  logic rsp_hs;
  assign rsp_hs = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stat_pass    <= '0;
      stat_fail    <= '0;
      stat_timeout <= '0;
    end else if (rsp_hs) begin
      if (rsp_timeout) begin
        if (stat_timeout != 16'hFFFF) stat_timeout <= stat_timeout + 1'b1;
      end else if (rsp_pass) begin
        if (stat_pass != 16'hFFFF) stat_pass <= stat_pass + 1'b1;
      end else begin
        if (stat_fail != 16'hFFFF) stat_fail <= stat_fail + 1'b1;
      end
    end
  end
`endif

endmodule
